// File: rtl/tmds_pkg.sv
// Shared TMDS constants: symbol-class codes, control tokens, guard bands and the
// TERC4 table, all stored in tmds[9:0] order (bit 0 leaves the serialiser first).
package tmds_pkg;

  localparam int DISP_W = 5;

  localparam logic [2:0] MODE_CTRL   = 3'd0;
  localparam logic [2:0] MODE_VIDEO  = 3'd1;
  localparam logic [2:0] MODE_VGUARD = 3'd2;
  localparam logic [2:0] MODE_DGUARD = 3'd3;
  localparam logic [2:0] MODE_TERC4  = 3'd4;

  // Indexed by {C1,C0}; each entry is the transmit string bit-reversed.
  localparam logic [3:0][9:0] CTRL_TOKEN = {
    10'b1010101011,   // 11
    10'b0101010100,   // 10
    10'b0010101011,   // 01
    10'b1101010100    // 00
  };

  localparam logic [9:0] VGUARD_0_2 = 10'b0011001101;
  localparam logic [9:0] VGUARD_1   = 10'b1100110010;
  localparam logic [9:0] DGUARD_1_2 = 10'b1100110010;

  localparam logic [15:0][9:0] TERC4_LUT = {
    10'b1100001101,   // 15
    10'b1100011010,   // 14
    10'b1000111001,   // 13
    10'b0111000101,   // 12
    10'b0110001101,   // 11
    10'b0011100110,   // 10
    10'b1001110010,   // 9
    10'b0011001101,   // 8
    10'b0011110010,   // 7
    10'b0111000110,   // 6
    10'b0111100010,   // 5
    10'b1000111010,   // 4
    10'b0100011101,   // 3
    10'b0010011101,   // 2
    10'b1100011001,   // 1
    10'b0011100101    // 0
  };

  // Ones minus zeros of an 8-bit word, range -8..+8.
  function automatic logic signed [DISP_W-1:0] disparity(input logic [7:0] b);
    logic [3:0]        n1;
    logic [DISP_W-1:0] two_n1;
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + 4'(b[i]);
    two_n1 = {n1, 1'b0};
    return $signed(two_n1 - 5'd8);
  endfunction

endpackage

// File: rtl/tmds_terc4.sv
// TERC4 data-island lookup: one 4-bit nibble to one 10-bit symbol, purely combinational.
module tmds_terc4
  import tmds_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [9:0] sym
);

  assign sym = TERC4_LUT[nibble];

endmodule

// File: rtl/tmds_stage_2.sv
// DC-balancing back half of a TMDS channel encoder with a fixed two-stage pipeline.
// Define TMDS_DATA_ISLAND_EN to enable the TERC4 / data-guard path.
module tmds_stage_2
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode,
  input  logic [8:0] q_m,
  input  logic [1:0] ctrl,
  input  logic [3:0] aux_d,
  output logic [9:0] tmds
);

  localparam logic [9:0] VGUARD_SYM = (CHANNEL == 1) ? VGUARD_1 : VGUARD_0_2;

  logic [2:0]               mode_a;
  logic [8:0]               q_m_a;
  logic [1:0]               ctrl_a;
  logic signed [DISP_W-1:0] d_a;
  logic signed [DISP_W-1:0] cnt;
  logic signed [DISP_W-1:0] cnt_nxt;
  logic signed [DISP_W-1:0] two_q8;
  logic signed [DISP_W-1:0] two_nq8;
  logic [9:0]               sym;

  // Stage A: register the inputs and pre-compute the word disparity.
  // NOTE: reset is synchronous, so only the clock edge appears in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      mode_a <= MODE_CTRL;
      ctrl_a <= 2'b00;
      q_m_a  <= '0;
      d_a    <= '0;
    end else begin
      mode_a <= mode;
      ctrl_a <= ctrl;
      q_m_a  <= q_m;
      d_a    <= disparity(q_m[7:0]);
    end
  end

`ifdef TMDS_DATA_ISLAND_EN
  logic [3:0] aux_a;
  logic [9:0] terc4_sym;

  always_ff @(posedge clk) begin
    if (!rst_n) aux_a <= '0;
    else        aux_a <= aux_d;
  end

  tmds_terc4 u_terc4 (
    .nibble (aux_a),
    .sym    (terc4_sym)
  );
`else
  logic unused_aux;
  assign unused_aux = ^aux_d;
`endif

  assign two_q8  = {3'b000, q_m_a[8], 1'b0};
  assign two_nq8 = {3'b000, ~q_m_a[8], 1'b0};

  // Stage B symbol select; any non-VIDEO symbol clears the running disparity.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    sym     = CTRL_TOKEN[ctrl_a];
    cnt_nxt = '0;
    case (mode_a)
      MODE_VIDEO: begin
        if (cnt == '0 || d_a == '0) begin
          sym     = {~q_m_a[8], q_m_a[8], q_m_a[8] ? q_m_a[7:0] : ~q_m_a[7:0]};
          cnt_nxt = q_m_a[8] ? cnt + d_a : cnt - d_a;
        end else if (cnt[DISP_W-1] == d_a[DISP_W-1]) begin
          // Same sign: invert the data to pull the running disparity back toward zero.
          sym     = {1'b1, q_m_a[8], ~q_m_a[7:0]};
          cnt_nxt = cnt + two_q8 - d_a;
        end else begin
          sym     = {1'b0, q_m_a[8], q_m_a[7:0]};
          cnt_nxt = cnt - two_nq8 + d_a;
        end
      end
      MODE_VGUARD: sym = VGUARD_SYM;
`ifdef TMDS_DATA_ISLAND_EN
      MODE_DGUARD: sym = (CHANNEL == 0) ? terc4_sym : DGUARD_1_2;
      MODE_TERC4:  sym = terc4_sym;
`else
      MODE_DGUARD, MODE_TERC4: sym = CTRL_TOKEN[ctrl_a];
`endif
      default: sym = CTRL_TOKEN[ctrl_a];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmds <= CTRL_TOKEN[2'b00];
      cnt  <= '0;
    end else begin
      tmds <= sym;
      cnt  <= cnt_nxt;
    end
  end

endmodule
